mem_access_stage: RTL and testbench

//  MEM pipeline stage. Sits between the EX/MEM and MEM/WB registers: takes ALU result, store data and

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared size codes, FSM states and byte-enable constants for the MEM stage.
package mem_stage_pkg;

   localparam logic [1:0] SZ_BYTE     = 2'b00;
   localparam logic [1:0] SZ_HALF     = 2'b01;
   localparam logic [1:0] SZ_WORD     = 2'b10;
   localparam logic [1:0] SZ_WORD_ALT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_RETIRE = 2'd2
   } state_e;

   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational store lane replication, byte-enable generation,
// load extraction/extension and misalignment detection for a 4-lane little-endian bus.
module mem_lane_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        addr_lo_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [3:0]        be_o,
   output logic [DATA_W-1:0] load_data_o,
   output logic              misaligned_o
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      wdata_o      = store_data_i;
      be_o         = BE_WORD;
      misaligned_o = 1'b0;
      unique case (size_i)
         SZ_BYTE: begin
            wdata_o = {4{store_data_i[7:0]}};
            be_o    = BE_BYTE0 << addr_lo_i;
         end
         SZ_HALF: begin
            wdata_o      = {2{store_data_i[15:0]}};
            be_o         = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
            misaligned_o = addr_lo_i[0];
         end
         default: begin
            misaligned_o = |addr_lo_i;
         end
      endcase
   end

   // Sign bit is masked by unsigned_i so one replication covers both extensions.
   always_comb begin
      rd_byte     = rdata_i[{addr_lo_i, 3'b000} +: 8];
      rd_half     = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
      load_data_o = rdata_i;
      unique case (size_i)
         SZ_BYTE: load_data_o = {{(DATA_W-8){rd_byte[7] & ~unsigned_i}}, rd_byte};
         SZ_HALF: load_data_o = {{(DATA_W-16){rd_half[15] & ~unsigned_i}}, rd_half};
         default: load_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: one req/ack data-memory transaction per load/store,
// with wait-state stalling, timeout and misalignment flags, and a one-cycle MEM/WB write pulse.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int WAIT_MAX = 15
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic [1:0]        size_in,
   input  logic              unsigned_in,
   output logic              stall_out,
   output logic [DATA_W-1:0] result_out,
   output logic [DATA_W-1:0] load_data_out,
   output logic              wb_write,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              misalign_err,
   output logic              timeout_err
);

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

   state_e            state_q;
   logic [7:0]        cnt_q;
   logic [7:0]        cnt_d;
   logic [DATA_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic              load_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] load_data_q;
   logic              wb_write_q;
   logic              req_q;
   logic              we_q;
   logic [DATA_W-1:0] dmem_addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        be_q;
   logic              misalign_q;
   logic              timeout_q;

   logic              in_idle;
   logic              mem_op;
   logic [1:0]        lane_addr_lo;
   logic [1:0]        lane_size;
   logic              lane_uns;
   logic [DATA_W-1:0] lane_wdata;
   logic [3:0]        lane_be;
   logic [DATA_W-1:0] lane_load;
   logic              lane_misaligned;

   assign in_idle = (state_q == ST_IDLE);
   assign mem_op  = mem_read_in | mem_write_in;
   assign cnt_d   = cnt_q + 8'd1;

   // IDLE aligns the incoming instruction; BUSY extracts load data using the latched op.
   assign lane_addr_lo = in_idle ? alu_result_in[1:0] : addr_q[1:0];
   assign lane_size    = in_idle ? size_in : size_q;
   assign lane_uns     = in_idle ? unsigned_in : uns_q;

   mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
      .addr_lo_i    (lane_addr_lo),
      .size_i       (lane_size),
      .unsigned_i   (lane_uns),
      .store_data_i (store_data_in),
      .rdata_i      (dmem_rdata),
      .wdata_o      (lane_wdata),
      .be_o         (lane_be),
      .load_data_o  (lane_load),
      .misaligned_o (lane_misaligned)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         load_q      <= 1'b0;
         result_q    <= '0;
         load_data_q <= '0;
         wb_write_q  <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         dmem_addr_q <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         misalign_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         wb_write_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (valid_in) begin
                  if (!mem_op) begin
                     result_q   <= alu_result_in;
                     wb_write_q <= 1'b1;
                  end else if (lane_misaligned) begin
                     misalign_q <= 1'b1;
                  end else begin
                     addr_q      <= alu_result_in;
                     size_q      <= size_in;
                     uns_q       <= unsigned_in;
                     load_q      <= mem_read_in;
                     req_q       <= 1'b1;
                     we_q        <= mem_write_in;
                     dmem_addr_q <= {alu_result_in[DATA_W-1:2], 2'b00};
                     wdata_q     <= lane_wdata;
                     be_q        <= lane_be;
                     cnt_q       <= '0;
                     state_q     <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (dmem_ack) begin
                  req_q      <= 1'b0;
                  we_q       <= 1'b0;
                  result_q   <= addr_q;
                  wb_write_q <= 1'b1;
                  if (load_q) begin
                     load_data_q <= lane_load;
                  end
                  state_q <= ST_RETIRE;
               end else if (cnt_d == WAIT_LIM) begin
                  req_q     <= 1'b0;
                  we_q      <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RETIRE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Only the stall is combinational: upstream must freeze in the same cycle the op is seen.
   assign stall_out = (in_idle & valid_in & mem_op & ~lane_misaligned) | (state_q == ST_BUSY);

   assign result_out    = result_q;
   assign load_data_out = load_data_q;
   assign wb_write      = wb_write_q;
   assign dmem_req      = req_q;
   assign dmem_we       = we_q;
   assign dmem_addr     = dmem_addr_q;
   assign dmem_wdata    = wdata_q;
   assign dmem_be       = be_q;
   assign misalign_err  = misalign_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

   logic        clock;
   logic        clear_n;
   logic        valid_in;
   logic [31:0] alu_result_in;
   logic [31:0] store_data_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [1:0]  size_in;
   logic        unsigned_in;
   logic        stall_out;
   logic [31:0] result_out;
   logic [31:0] load_data_out;
   logic        wb_write;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        misalign_err;
   logic        timeout_err;

   int passed = 0;
   int total  = 0;

   mem_access_stage #(.DATA_W(32), .WAIT_MAX(4)) dut (
      .clock         (clock),
      .clear_n       (clear_n),
      .valid_in      (valid_in),
      .alu_result_in (alu_result_in),
      .store_data_in (store_data_in),
      .mem_read_in   (mem_read_in),
      .mem_write_in  (mem_write_in),
      .size_in       (size_in),
      .unsigned_in   (unsigned_in),
      .stall_out     (stall_out),
      .result_out    (result_out),
      .load_data_out (load_data_out),
      .wb_write      (wb_write),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_be       (dmem_be),
      .dmem_rdata    (dmem_rdata),
      .dmem_ack      (dmem_ack),
      .misalign_err  (misalign_err),
      .timeout_err   (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic uns);
      valid_in      = 1'b1;
      alu_result_in = a;
      store_data_in = sd;
      mem_read_in   = rd;
      mem_write_in  = wr;
      size_in       = sz;
      unsigned_in   = uns;
   endtask

   task automatic idle_in();
      valid_in     = 1'b0;
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
   endtask

   initial begin
      logic [31:0] lb_exp [2];
      lb_exp[0] = 32'hFFFF_FF80;
      lb_exp[1] = 32'h0000_0080;

      clear_n       = 1'b0;
      valid_in      = 1'b0;
      alu_result_in = '0;
      store_data_in = '0;
      mem_read_in   = 1'b0;
      mem_write_in  = 1'b0;
      size_in       = 2'b00;
      unsigned_in   = 1'b0;
      dmem_rdata    = '0;
      dmem_ack      = 1'b0;

      tick();
      tick();
      check("rst_wb_write", wb_write, 0);
      check("rst_req", dmem_req, 0);
      check("rst_stall", stall_out, 0);
      check("rst_result", result_out, 0);
      check("rst_misalign", misalign_err, 0);
      check("rst_timeout", timeout_err, 0);
      clear_n = 1'b1;

      // ALU op retires one cycle later with no bus activity
      issue(32'h0000_1234, 0, 0, 0, 2'b10, 0);
      #1 check("alu_stall", stall_out, 0);
      tick();
      idle_in();
      check("alu_wb_write", wb_write, 1);
      check("alu_result", result_out, 32'h0000_1234);
      check("alu_no_req", dmem_req, 0);
      tick();
      check("alu_wb_pulse_end", wb_write, 0);

      // LW 0x100, ack on the third request cycle
      issue(32'h0000_0100, 0, 1, 0, 2'b10, 0);
      #1 check("lw_stall_idle", stall_out, 1);
      tick();
      idle_in();
      check("lw_req_c1", dmem_req, 1);
      check("lw_we", dmem_we, 0);
      check("lw_be", dmem_be, 4'b1111);
      check("lw_addr", dmem_addr, 32'h0000_0100);
      check("lw_stall_c1", stall_out, 1);
      tick();
      check("lw_req_c2", dmem_req, 1);
      tick();
      check("lw_req_c3", dmem_req, 1);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      #1 check("lw_stall_ack", stall_out, 1);
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      check("lw_req_drop", dmem_req, 0);
      check("lw_wb_write", wb_write, 1);
      check("lw_load_data", load_data_out, 32'hDEAD_BEEF);
      check("lw_result", result_out, 32'h0000_0100);
      check("lw_stall_retire", stall_out, 0);
      tick();
      check("lw_wb_pulse_end", wb_write, 0);

      // LB 0x103, signed then unsigned
      for (int u = 0; u < 2; u++) begin
         issue(32'h0000_0103, 0, 1, 0, 2'b00, u[0]);
         tick();
         idle_in();
         check("lb_addr", dmem_addr, 32'h0000_0100);
         dmem_ack   = 1'b1;
         dmem_rdata = 32'h8000_0000;
         tick();
         dmem_ack = 1'b0;
         check("lb_wb_write", wb_write, 1);
         check(u == 0 ? "lb_signed" : "lb_unsigned", load_data_out, lb_exp[u]);
         tick();
      end

      // SH 0x102 with zero-wait ack
      issue(32'h0000_0102, 32'h0000_ABCD, 0, 1, 2'b01, 0);
      tick();
      idle_in();
      check("sh_req", dmem_req, 1);
      check("sh_we", dmem_we, 1);
      check("sh_be", dmem_be, 4'b1100);
      check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
      check("sh_addr", dmem_addr, 32'h0000_0100);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      check("sh_wb_write", wb_write, 1);
      check("sh_req_drop", dmem_req, 0);
      check("sh_we_drop", dmem_we, 0);
      tick();

      // SB 0x101
      issue(32'h0000_0101, 32'h0000_0012, 0, 1, 2'b00, 0);
      tick();
      idle_in();
      check("sb_be", dmem_be, 4'b0010);
      check("sb_wdata", dmem_wdata, 32'h1212_1212);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      check("sb_wb_write", wb_write, 1);
      tick();

      // Misaligned LW 0x101, then an ALU op retires normally
      issue(32'h0000_0101, 0, 1, 0, 2'b10, 0);
      #1 check("mis_stall", stall_out, 0);
      tick();
      check("mis_err", misalign_err, 1);
      check("mis_no_req", dmem_req, 0);
      check("mis_no_wb", wb_write, 0);
      issue(32'h0000_0055, 0, 0, 0, 2'b10, 0);
      tick();
      idle_in();
      check("mis_alu_wb", wb_write, 1);
      check("mis_alu_result", result_out, 32'h0000_0055);
      tick();

      // Timeout with WAIT_MAX=4
      issue(32'h0000_0200, 0, 1, 0, 2'b10, 0);
      tick();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         check("to_req_held", dmem_req, 1);
         tick();
      end
      check("to_req_drop", dmem_req, 0);
      check("to_err", timeout_err, 1);
      check("to_stall", stall_out, 0);
      check("to_no_wb", wb_write, 0);
      check("to_misalign_sticky", misalign_err, 1);

      // Reset mid-BUSY
      issue(32'h0000_0200, 0, 1, 0, 2'b10, 0);
      tick();
      idle_in();
      check("rst2_req_before", dmem_req, 1);
      #3 clear_n = 1'b0;
      #1;
      check("rst2_req", dmem_req, 0);
      check("rst2_timeout", timeout_err, 0);
      check("rst2_misalign", misalign_err, 0);
      check("rst2_result", result_out, 0);
      check("rst2_load", load_data_out, 0);
      check("rst2_stall", stall_out, 0);
      check("rst2_wb", wb_write, 0);
      #2 clear_n = 1'b1;
      tick();
      issue(32'h0000_0077, 0, 0, 0, 2'b10, 0);
      tick();
      idle_in();
      check("post_rst_wb", wb_write, 1);
      check("post_rst_result", result_out, 32'h0000_0077);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
